// File: rtl/up_dn_counter_if.sv
// Bundle of the load/count request inputs and the count/flag outputs of
// up_dn_counter.
//   IN      : parallel load value
//   Load    : load request (highest priority below reset)
//   Up      : increment request
//   Down    : decrement request (beats Up)
//   Counter : current registered count
//   High    : Counter is at its maximum
//   Low     : Counter is zero
// The master modport drives the requests; the slave modport is the counter itself.
interface up_dn_counter_if #(
  parameter int unsigned WIDTH = 5
) ();
  logic [WIDTH-1:0] IN;
  logic             Load;
  logic             Up;
  logic             Down;
  logic [WIDTH-1:0] Counter;
  logic             High;
  logic             Low;

  modport master (
    output IN,
    output Load,
    output Up,
    output Down,
    input  Counter,
    input  High,
    input  Low
  );

  modport slave (
    input  IN,
    input  Load,
    input  Up,
    input  Down,
    output Counter,
    output High,
    output Low
  );
endinterface

// File: rtl/up_dn_counter.sv
// Saturating up/down counter with parallel load and boundary flags.
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset, clears the count
//   bus : slave side of up_dn_counter_if (IN/Load/Up/Down in, Counter/High/Low out)
// Priority per edge: rst, Load, Down, Up, hold. The count never wraps; a
// request that would cross a limit leaves the count at that limit.
module up_dn_counter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic           clk,
  input  logic           rst,
  up_dn_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MaxCount = '1;
  localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

  logic [WIDTH-1:0] counter_d;
  logic [WIDTH-1:0] counter_q;
  logic             high;
  logic             low;

  // Flags decode the register only, so they move in the same cycle as Counter.
  assign high = (counter_q == MaxCount);
  assign low  = (counter_q == '0);

  // Saturation tests the current value, not the computed result.
  always_comb begin
    counter_d = counter_q;
    if (bus.Load) begin
      counter_d = bus.IN;
    end else if (bus.Down) begin
      if (!low) begin
        counter_d = counter_q - CountOne;
      end
    end else if (bus.Up) begin
      if (!high) begin
        counter_d = counter_q + CountOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter_q <= '0;
    end else begin
      counter_q <= counter_d;
    end
  end

  assign bus.Counter = counter_q;
  assign bus.High    = high;
  assign bus.Low     = low;

endmodule

// File: tb/tb_up_dn_counter.sv
// Self-checking bench for up_dn_counter. A driver applies one vector per
// clock on the falling edge and pushes the expected post-edge state, taken
// from an integer reference model, into a queue. A monitor pops and compares
// shortly after every rising edge.
module tb_up_dn_counter;

  localparam int unsigned WIDTH = 5;
  localparam int MAX = (1 << WIDTH) - 1;

  typedef struct {
    logic [WIDTH-1:0] cnt;
    logic             hi;
    logic             lo;
  } exp_t;

  logic clk;
  logic rst;

  up_dn_counter_if #(.WIDTH(WIDTH)) bus ();

  up_dn_counter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  exp_t mon_e;
  int   model;
  int   n_vec;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic with clamping at 0 and MAX.
  task automatic apply(input logic r, input logic ld, input logic up, input logic dn,
                       input int val);
    exp_t e;
    @(negedge clk);
    rst      = r;
    bus.Load = ld;
    bus.Up   = up;
    bus.Down = dn;
    bus.IN   = WIDTH'(val);
    if (r)       model = 0;
    else if (ld) model = val;
    else if (dn) model = (model > 0) ? model - 1 : 0;
    else if (up) model = (model < MAX) ? model + 1 : MAX;
    e.cnt = WIDTH'(model);
    e.hi  = (model == MAX);
    e.lo  = (model == 0);
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      if (bus.Counter !== mon_e.cnt || bus.High !== mon_e.hi || bus.Low !== mon_e.lo) begin
        n_err++;
        $display("FAIL count_check vec %0d: got Counter=%0d High=%b Low=%b, expected Counter=%0d High=%b Low=%b",
                 n_vec, bus.Counter, bus.High, bus.Low, mon_e.cnt, mon_e.hi, mon_e.lo);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors checked", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    int len;
    int mode;
    int sel;
    int v;
    n_vec    = 0;
    n_err    = 0;
    model    = 0;
    rst      = 1'b0;
    bus.Load = 1'b0;
    bus.Up   = 1'b0;
    bus.Down = 1'b0;
    bus.IN   = '0;

    // Reset beats Load.
    apply(1'b1, 1'b1, 1'b0, 1'b0, 15);
    // Load beats Up.
    apply(1'b0, 1'b1, 1'b1, 1'b0, 15);
    // Count down to the floor and past it.
    for (int i = 0; i < 17; i++) apply(1'b0, 1'b0, 1'b0, 1'b1, 0);
    // Count up to the ceiling and past it.
    for (int i = 0; i < 34; i++) apply(1'b0, 1'b0, 1'b1, 1'b0, 0);
    // Up and Down together decrement, and hold at 0.
    apply(1'b0, 1'b1, 1'b0, 1'b0, 10);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 0);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 0);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 0);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 0);
    // Load of MAX raises High.
    apply(1'b0, 1'b1, 1'b0, 1'b0, MAX);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 0);
    // Hold, then reset mid-count and resume.
    apply(1'b0, 1'b1, 1'b0, 1'b0, 20);
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b0, 1'b0, 1'b0, 7);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 0);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 0);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 9);
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b1, 1'b0, 0);

    // Random bursts: each burst favours one direction so limits get reached.
    for (int b = 0; b < 80; b++) begin
      len  = $urandom_range(1, 45);
      mode = $urandom_range(0, 3);
      for (int i = 0; i < len; i++) begin
        sel = $urandom_range(0, 99);
        case ($urandom_range(0, 3))
          0:       v = 0;
          1:       v = MAX;
          default: v = $urandom_range(0, MAX);
        endcase
        if (sel < 2) begin
          apply(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, v);
        end else if (sel < 8) begin
          apply(1'b0, 1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, v);
        end else begin
          case (mode)
            0:       apply(1'b0, 1'b0, 1'b1, 1'b0, v);
            1:       apply(1'b0, 1'b0, 1'b0, 1'b1, v);
            2:       apply(1'b0, 1'b0, 1'b1, 1'b1, v);
            default: apply(1'b0, 1'b0, $urandom_range(0, 1) == 1,
                           $urandom_range(0, 1) == 1, v);
          endcase
        end
      end
    end

    apply(1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries never checked, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
